// File: rtl/vga_scan_if.sv
// VRAM scan port plus the VGA connector pins driven by the scan front end.
interface vga_scan_if;
  logic [19:0] vram_scan_addr;
  logic [15:0] vram_scan_data;
  logic        hs;
  logic        vs;
  logic [3:0]  r;
  logic [3:0]  g;
  logic [3:0]  b;
  logic        blank;
  logic        frame_start;

  modport master (
    output vram_scan_addr, hs, vs, r, g, b, blank, frame_start,
    input  vram_scan_data
  );

  modport slave (
    input  vram_scan_addr, hs, vs, r, g, b, blank, frame_start,
    output vram_scan_data
  );
endinterface

// File: rtl/vga_scan.sv
// VGA timing generator with a linear VRAM scan pointer and a 2-stage
// counter-to-pin pipeline (address stage, then registered pins).
module vga_scan #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter logic [19:0] VRAM_BASE = 20'h00000
) (
  input logic        clk_25mhz,
  input logic        rst_n,
  input logic        en,
  vga_scan_if.master bus
);

  localparam int unsigned AW       = 20;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW       = $clog2(H_TOTAL);
  localparam int unsigned VW       = $clog2(V_TOTAL);
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [AW-1:0] ptr;
  logic          en_frame;

  logic          h_last_c;
  logic          v_last_c;
  logic          active_c;
  logic          hsync_c;
  logic          vsync_c;
  logic          origin_c;
  logic          en_eff_c;

  logic          live_s1;
  logic          blank_s1;
  logic          hs_s1;
  logic          vs_s1;
  logic          fs_s1;

  logic          unused_data_bits;

  // Position decode; en is taken directly at (0,0) so a new frame's first pixel follows it.
  always_comb begin
    h_last_c = (h_cnt == HW'(H_TOTAL - 1));
    v_last_c = (v_cnt == VW'(V_TOTAL - 1));
    active_c = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
    hsync_c  = (h_cnt >= HW'(HS_START)) && (h_cnt < HW'(HS_END));
    vsync_c  = (v_cnt >= VW'(VS_START)) && (v_cnt < VW'(VS_END));
    origin_c = (h_cnt == '0) && (v_cnt == '0);
    en_eff_c = origin_c ? en : en_frame;
  end

  assign unused_data_bits = ^{bus.vram_scan_data[11], bus.vram_scan_data[6:5],
                              bus.vram_scan_data[0]};

  always_ff @(posedge clk_25mhz) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last_c) begin
      h_cnt <= '0;
      v_cnt <= v_last_c ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  // Stage 1: frame enable, scan pointer and address, delayed timing flags.
  always_ff @(posedge clk_25mhz) begin
    if (!rst_n) begin
      en_frame           <= 1'b0;
      ptr                <= VRAM_BASE;
      bus.vram_scan_addr <= VRAM_BASE;
      live_s1            <= 1'b0;
      blank_s1           <= 1'b1;
      hs_s1              <= 1'b1;
      vs_s1              <= 1'b1;
      fs_s1              <= 1'b0;
    end else begin
      if (origin_c) begin
        en_frame <= en;
      end
      if (h_last_c && v_last_c) begin
        ptr <= VRAM_BASE;
      end else if (active_c && en_eff_c) begin
        ptr <= ptr + AW'(1);
      end
      if (!en_eff_c) begin
        bus.vram_scan_addr <= VRAM_BASE;
      end else if (active_c) begin
        bus.vram_scan_addr <= ptr;
      end
      live_s1  <= active_c && en_eff_c;
      blank_s1 <= !active_c;
      hs_s1    <= !hsync_c;
      vs_s1    <= !vsync_c;
      fs_s1    <= origin_c;
    end
  end

  // Stage 2: pins, RGB565 reduced to 4 bits per channel.
  always_ff @(posedge clk_25mhz) begin
    if (!rst_n) begin
      bus.hs          <= 1'b1;
      bus.vs          <= 1'b1;
      bus.blank       <= 1'b1;
      bus.frame_start <= 1'b0;
      bus.r           <= '0;
      bus.g           <= '0;
      bus.b           <= '0;
    end else begin
      bus.hs          <= hs_s1;
      bus.vs          <= vs_s1;
      bus.blank       <= blank_s1;
      bus.frame_start <= fs_s1;
      if (live_s1) begin
        bus.r <= bus.vram_scan_data[15:12];
        bus.g <= bus.vram_scan_data[10:7];
        bus.b <= bus.vram_scan_data[4:1];
      end else begin
        bus.r <= '0;
        bus.g <= '0;
        bus.b <= '0;
      end
    end
  end

endmodule
